// File: rtl/parity_check16.sv
// Receive-side parity checker for 16-bit words. It forwards each word with an error tag
// through one registered valid/ready stage and keeps saturating/sticky error status.

module parity_xor_lane #(
  parameter int VEC_W = 4
) (
  input  logic [VEC_W-1:0] vec,
  output logic             par
);
  assign par = ^vec;
endmodule

module parity_check16 #(
  parameter int ODD      = 0,
  parameter int CNT_W    = 8,
  parameter int DROP_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  input  logic             s_par,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      m_data,
  output logic             m_err,
  input  logic             clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 4;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } rsp_t;

  logic [NUM_LANES-1:0][VEC_W-1:0] lane_data;
  logic [NUM_LANES-1:0]            lane_par;
  rsp_t                            rsp_q;
  logic                            bad, acc, fwd, bad_acc;

  assign lane_data = s_data;

  // Nibble-wide partial parities, folded together with the received parity bit.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    parity_xor_lane #(.VEC_W(VEC_W)) u_lane (
      .vec (lane_data[g]),
      .par (lane_par[g])
    );
  end

  assign bad     = ^{lane_par, s_par, (ODD != 0)};
  assign s_ready = !m_valid | m_ready;
  assign acc     = s_valid & s_ready;
  // Gating by acc keeps don't-care input data out of the status registers.
  assign bad_acc = acc & bad;
  assign fwd     = acc & !((DROP_ERR != 0) && bad);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      rsp_q   <= '0;
    end else if (fwd) begin
      m_valid <= 1'b1;
      rsp_q   <= '{data: s_data, err: bad};
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  assign m_data = rsp_q.data;
  assign m_err  = rsp_q.err;

  // A bad word accepted on the clear cycle is counted after the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (clr) begin
      err_cnt    <= CNT_W'(bad_acc);
      err_sticky <= bad_acc;
    end else if (bad_acc) begin
      err_sticky <= 1'b1;
      if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
    end
  end
endmodule
